// File: rtl/ef_smsdac_pkg.sv
// Shared encodings for the split-segment DAC element shuffler: modes, phases, monitor width.
// Combinational content only; no latency or flow control lives here.
package ef_smsdac_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_SHAPE1 = 2'd1,
      MODE_SHAPE2 = 2'd2,
      MODE_RANDOM = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2,
      P3 = 2'd3
   } phase_e;

   localparam int MON_W = 8;
   localparam logic signed [MON_W-1:0] ACC_MAX = 8'sd127;
   localparam logic signed [MON_W-1:0] ACC_MIN = -8'sd127;

endpackage

// File: rtl/ef_smsdac_seqgen.sv
// Split-polarity sequence generator: s is combinational from the current phase/pol state.
// State advances only on accepted odd codes; a mode change forces P0/pol=0 on the next edge.
module ef_smsdac_seqgen
   import ef_smsdac_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode,
   input  logic       r,
   input  logic       adv,
   input  logic       odd,
   output logic       s
);

   phase_e     phase, phase_nxt;
   logic       pol, pol_nxt;
   logic [1:0] mode_q;
   logic       step;

   assign step = adv & odd;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase  <= P0;
         pol    <= 1'b0;
         mode_q <= mode;
      end else begin
         phase  <= phase_nxt;
         pol    <= pol_nxt;
         mode_q <= mode;
      end
   end

   always_comb begin
      s         = 1'b1;
      phase_nxt = phase;
      pol_nxt   = pol;
      case (mode_e'(mode))
         MODE_STATIC: s = 1'b1;
         MODE_RANDOM: s = r;
         MODE_SHAPE1: begin
            if (phase == P0) begin
               s = r;
               if (step) begin
                  pol_nxt   = r;
                  phase_nxt = P1;
               end
            end else begin
               s = ~pol;
               if (step) phase_nxt = P0;
            end
         end
         MODE_SHAPE2: begin
            case (phase)
               P0: begin
                  s = r;
                  if (step) begin
                     pol_nxt   = r;
                     phase_nxt = P1;
                  end
               end
               P1: begin
                  s = ~pol;
                  if (step) phase_nxt = P2;
               end
               P2: begin
                  s = ~pol;
                  if (step) phase_nxt = P3;
               end
               default: begin
                  s = pol;
                  if (step) phase_nxt = P0;
               end
            endcase
         end
         default: s = 1'b1;
      endcase
      // A mode change wins over any advance requested in the same cycle.
      if (mode != mode_q) begin
         phase_nxt = P0;
         pol_nxt   = 1'b0;
      end
   end

endmodule

// File: rtl/ef_smsdac_mse_sbp.sv
// Splits v = x + x_c into two halves y_a + y_b = v; one-cycle registered output, valid/ready skid-free.
// Optional error monitor (err_acc, err_flag) compiled in with EF_SMSDAC_ERRMON_EN.
module ef_smsdac_mse_sbp
   import ef_smsdac_pkg::*;
#(
   parameter int W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              mode,
   input  logic                    r,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [W-1:0]            x,
   input  logic                    x_c,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [W-1:0]            y_a,
   output logic [W-1:0]            y_b
`ifdef EF_SMSDAC_ERRMON_EN
   ,
   output logic signed [MON_W-1:0] err_acc,
   output logic                    err_flag
`endif
);

   logic [W:0]   v;
   logic [W-1:0] half;
   logic [W-1:0] ya_nxt, yb_nxt;
   logic         acc, odd, s;

   assign v        = {1'b0, x} + (W+1)'(x_c);
   assign odd      = v[0];
   assign half     = v[W:1];
   assign in_ready = ~out_valid | out_ready;
   assign acc      = in_valid & in_ready;

   ef_smsdac_seqgen u_seqgen (
      .clk  (clk),
      .rst  (rst),
      .mode (mode),
      .r    (r),
      .adv  (acc),
      .odd  (odd),
      .s    (s)
   );

   // Odd codes put the extra unit on the half selected by s.
   always_comb begin
      ya_nxt = half;
      yb_nxt = half;
      if (odd) begin
         if (s) ya_nxt = half + 1'b1;
         else   yb_nxt = half + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         y_a       <= '0;
         y_b       <= '0;
      end else if (acc) begin
         out_valid <= 1'b1;
         y_a       <= ya_nxt;
         y_b       <= yb_nxt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef EF_SMSDAC_ERRMON_EN
   logic [1:0] mon_mode_q;
   logic       mon_chg, shaped;

   assign mon_chg = (mode != mon_mode_q);
   assign shaped  = (mode == MODE_SHAPE1) || (mode == MODE_SHAPE2);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_acc    <= '0;
         err_flag   <= 1'b0;
         mon_mode_q <= mode;
      end else begin
         mon_mode_q <= mode;
         if (mon_chg) begin
            err_acc <= '0;
         end else if (acc && odd) begin
            if (s && err_acc != ACC_MAX)       err_acc <= err_acc + 8'sd1;
            else if (!s && err_acc != ACC_MIN) err_acc <= err_acc - 8'sd1;
         end
         // Stale accumulator is ignored in the cycle the mode switches.
         if (!mon_chg && shaped && (err_acc > 8'sd1 || err_acc < -8'sd1))
            err_flag <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ef_smsdac_mse_sbp.sv
// Randomized + directed bench for ef_smsdac_mse_sbp with a queue scoreboard and a behavioural model.
module tb_ef_smsdac_mse_sbp;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   mode;
   logic         r;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x;
   logic         x_c;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y_a;
   logic [W-1:0] y_b;
`ifdef EF_SMSDAC_ERRMON_EN
   logic signed [7:0] err_acc;
   logic              err_flag;
`endif

   ef_smsdac_mse_sbp #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .r         (r),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .x_c       (x_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_a       (y_a),
      .y_b       (y_b)
`ifdef EF_SMSDAC_ERRMON_EN
      ,
      .err_acc   (err_acc),
      .err_flag  (err_flag)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int ya; int yb; } exp_t;
   exp_t q[$];

   int checks = 0;
   int errors = 0;

   // Behavioural model state: position in the shaping sequence, stored polarity,
   // pending output, running error sum and sticky flag.
   int k;
   bit pol;
   int prev_mode;
   bit m_ov;
   int e_acc;
   bit e_flag;

   task automatic chk(input string name, input logic signed [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic bit model_s(input int md, input bit ri);
      case (md)
         0: return 1'b1;
         3: return ri;
         1: return (k % 2 == 0) ? ri : !pol;
         default: begin
            if (k % 4 == 0) return ri;
            if (k % 4 == 3) return pol;
            return !pol;
         end
      endcase
   endfunction

   // Drive one cycle, update the model for the coming edge, then wait past that edge.
   task automatic step(input bit iv, input int xi, input bit xc, input bit ri,
                       input bit ordy, input int md);
      bit exp_rdy, acc, s;
      int v, ya;
      exp_t e;
`ifdef EF_SMSDAC_ERRMON_EN
      chk("err_acc", err_acc, e_acc);
      chk("err_flag", err_flag, int'(e_flag));
`endif
      in_valid  = iv;
      x         = W'(xi);
      x_c       = xc;
      r         = ri;
      out_ready = ordy;
      mode      = 2'(md);
      #1;
      exp_rdy = !m_ov || ordy;
      chk("in_ready", in_ready, int'(exp_rdy));
      acc = iv && exp_rdy;
      v   = xi + int'(xc);
      s   = model_s(md, ri);
      if (acc) begin
         if (v % 2 == 0) ya = v / 2;
         else            ya = s ? (v + 1) / 2 : (v - 1) / 2;
         e.ya = ya;
         e.yb = v - ya;
         q.push_back(e);
      end
      if (md == prev_mode && (md == 1 || md == 2) && (e_acc > 1 || e_acc < -1))
         e_flag = 1'b1;
      if (md != prev_mode) begin
         k = 0;
         pol = 1'b0;
         e_acc = 0;
         prev_mode = md;
      end else if (acc && (v % 2 == 1)) begin
         e_acc = e_acc + (s ? 1 : -1);
         if (e_acc > 127)  e_acc = 127;
         if (e_acc < -127) e_acc = -127;
         if (md == 1 || md == 2) begin
            if (k == 0) pol = ri;
            k = (k + 1) % ((md == 1) ? 2 : 4);
         end
      end
      if (acc)       m_ov = 1'b1;
      else if (ordy) m_ov = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y_a", y_a, 0);
      chk("rst_y_b", y_b, 0);
`ifdef EF_SMSDAC_ERRMON_EN
      chk("rst_err_acc", err_acc, 0);
      chk("rst_err_flag", err_flag, 0);
`endif
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", in_ready, 1);
      k = 0; pol = 1'b0; m_ov = 1'b0; e_acc = 0; e_flag = 1'b0;
      prev_mode = int'(mode);
      q.delete();
   endtask

   // Monitor: a transfer happens on any edge where out_valid and out_ready are both high.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output y_a=%0d y_b=%0d expected=none", y_a, y_b);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (y_a !== W'(e.ya) || y_b !== W'(e.yb)) begin
               errors++;
               $display("FAIL scoreboard got y_a=%0d y_b=%0d expected y_a=%0d y_b=%0d",
                        y_a, y_b, e.ya, e.yb);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur;
      int ra[4];
      int ea[4];
      int yexp[4];
      mode = 2'd0; r = 1'b0; x = '0; x_c = 1'b0;
      do_reset();

      // Static mode: odd code puts the extra unit on y_a, full-scale splits evenly.
      step(1, 7, 0, 0, 1, 0);
      chk("static7_y_a", y_a, 4);
      chk("static7_y_b", y_b, 3);
      step(1, 15, 1, 0, 1, 0);
      chk("static16_y_a", y_a, 8);
      chk("static16_y_b", y_b, 8);

      // Two-phase shaping.
      step(0, 0, 0, 0, 1, 1);
      ra = '{1, 0, 0, 1};
      yexp = '{3, 2, 2, 3};
      ea = '{1, 0, -1, 0};
      for (int i = 0; i < 4; i++) begin
         step(1, 5, 0, ra[i][0], 1, 1);
         chk("shape1_y_a", y_a, yexp[i]);
`ifdef EF_SMSDAC_ERRMON_EN
         chk("shape1_err_acc", err_acc, ea[i]);
`endif
      end

      // Four-phase shaping with even codes interleaved (no phase advance on even).
      step(0, 0, 0, 0, 1, 2);
      step(1, 3, 0, 0, 1, 2); chk("shape2_p0", y_a, 1);
      step(1, 4, 0, 1, 1, 2); chk("shape2_even", y_a, 2);
      step(1, 3, 0, 1, 1, 2); chk("shape2_p1", y_a, 2);
      step(1, 4, 0, 0, 1, 2); chk("shape2_even2", y_a, 2);
      step(1, 3, 0, 1, 1, 2); chk("shape2_p2", y_a, 2);
      step(1, 3, 0, 1, 1, 2); chk("shape2_p3", y_a, 1);

      // Backpressure: outputs frozen, no acceptance, then release accepts immediately.
      step(1, 5, 0, 1, 1, 2);
      chk("bp_first_y_a", y_a, 3);
      for (int i = 0; i < 3; i++) begin
         step(1, 7, 0, 0, 0, 2);
         chk("bp_hold_y_a", y_a, 3);
         chk("bp_hold_valid", out_valid, 1);
      end
      step(1, 7, 0, 0, 1, 2);
      chk("bp_release_y_b", y_b, 4);

      // Mode switch in P1 restarts the next sequence at P0.
      step(0, 0, 0, 0, 1, 1);
      step(1, 5, 0, 1, 1, 1);
      step(0, 0, 0, 0, 1, 2);
      step(1, 5, 0, 1, 1, 2);
      chk("switch_p0_y_a", y_a, 3);

      // Random mode with r stuck high drives the accumulator into saturation.
      step(0, 0, 0, 0, 1, 3);
      for (int i = 0; i < 130; i++) step(1, 1, 0, 1, 1, 3);
      chk("rand_y_a", y_a, 1);
`ifdef EF_SMSDAC_ERRMON_EN
      chk("sat_err_acc", err_acc, 127);
      chk("sat_err_flag", err_flag, 0);
`endif

      // Reset with a held output pending, FSM left in P1 beforehand.
      step(0, 0, 0, 0, 1, 1);
      step(1, 5, 0, 1, 0, 1);
      chk("pre_rst_valid", out_valid, 1);
      do_reset();
      step(1, 5, 0, 1, 1, 1);
      chk("post_rst_p0_y_a", y_a, 3);

      // Randomized traffic; mode changes happen on idle cycles.
      cur = 1;
      for (int i = 0; i < 400; i++) begin
         int md;
         bit iv;
         md = cur;
         if ($urandom_range(15) == 0) md = int'($urandom_range(3));
         iv = (md == cur) ? ($urandom_range(3) != 0) : 1'b0;
         step(iv, int'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              $urandom_range(3) != 0, md);
         cur = md;
      end

      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, cur);
      chk("scoreboard_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ef_smsdac_mse_sbp.md
EF_SMSDAC_MSE_SBP -- requirements
Module: ef_smsdac_mse_sbp

Interface
REQ-001 SHALL have parameter W, default 4, input code width, legal range 2..12.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port mode, input, 2, sequence select: 0 STATIC, 1 SHAPE1, 2 SHAPE2, 3 RANDOM.
REQ-005 SHALL have port r, input, 1, external random bit, sampled only on accepted odd inputs.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), x (input, W), x_c (input, 1).
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), y_a (output, W), y_b (output, W).
REQ-008 SHALL have, only with EF_SMSDAC_ERRMON_EN, ports err_acc (output, 8, signed) and err_flag (output, 1).

Function
REQ-009 SHALL form v = x + x_c, unsigned, W+1 bits, range 0..2^W.
REQ-010 SHALL accept an input when in_valid and in_ready are both high; in_ready = ~out_valid | out_ready.
REQ-011 SHALL register y_a, y_b one cycle after acceptance, with out_valid set; out_valid clears on out_ready without a new accept.
REQ-012 SHALL hold y_a, y_b, out_valid stable while out_valid & ~out_ready.
REQ-013 SHALL compute y_a = (v+d)/2, y_b = (v-d)/2, d = 0 for even v, d = +1 for odd v with s=1, d = -1 for odd v with s=0; y_a + y_b = v always.
REQ-014 SHALL advance sequence state only on accepted odd v; even or unaccepted inputs leave state unchanged.
REQ-015 STATIC: s = 1; no state change.
REQ-016 RANDOM: s = r; no state change.
REQ-017 SHAPE1: two-phase FSM P0/P1. In P0: s = r, store pol = r, go to P1. In P1: s = ~pol, go to P0.
REQ-018 SHAPE2: four-phase FSM P0..P3. In P0: s = r, store pol = r. P1 and P2: s = ~pol. P3: s = pol. P3 wraps to P0.
REQ-019 SHALL return the FSM to P0 and clear pol in the cycle after any change of mode, overriding a same-cycle advance.
REQ-020 SHALL sample mode on the same edge as the accepted input.

Reset
REQ-021 On rst: out_valid = 0, y_a = 0, y_b = 0, FSM = P0, pol = 0; err_acc = 0 and err_flag = 0 when compiled in.
REQ-022 Reset mid-transfer SHALL discard the pending output; in_ready SHALL be 1 in the cycle after rst deasserts.

Configuration
REQ-023 With EF_SMSDAC_ERRMON_EN defined:
- err_acc is the saturating (±127) running sum of d over accepted inputs.
- err_acc clears on mode change, using the same cycle rule as REQ-019.
- err_flag is sticky, set when |err_acc| > 1 in SHAPE1 or SHAPE2, cleared only by rst.
REQ-024 Without EF_SMSDAC_ERRMON_EN, the monitor ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package ef_smsdac_pkg SHALL hold the mode encodings, the FSM phase encodings P0..P3 and the monitor width (8).
REQ-026 The sequence FSM SHALL be sub-module ef_smsdac_seqgen:
- inputs: clk, rst, mode, r, adv, odd
- output: s, combinational from current state

Verification
REQ-027 W=4, mode=0, x=7, x_c=0 -> y_a=4, y_b=3 one cycle later; x=15, x_c=1 -> y_a=8, y_b=8.
REQ-028 mode=1, four accepted odd inputs v=5 with r=1,0,0,1 -> y_a = 3,2,2,3; err_acc = 1,0,-1,0.
REQ-029 mode=2, four odd v=3 with r=0 at P0 -> s = 0,1,1,0, y_a = 1,2,2,1; even v=4 interleaved -> y_a=2, no phase advance.
REQ-030 out_ready held low 3 cycles with in_valid high -> in_ready=0, outputs frozen, no FSM advance; release -> next input accepted the same cycle.
REQ-031 mode 1->2 switched in P1 -> next odd input uses P0 (s=r); mode=3 with r=1 repeatedly -> err_acc saturates at 127, err_flag stays 0.
REQ-032 rst asserted with out_valid=1 -> out_valid=0, y_a=0, y_b=0 next cycle; FSM in P0.
